// File: rtl/divider_request_controller_pkg.sv
// Shared encodings, FSM states and defaults for the divider request controller.
// Op field bits: [2] word variant, [1] remainder, [0] unsigned.
package divider_request_controller_pkg;

  localparam int DEFAULT_W     = 64;
  localparam int DEFAULT_TAG_W = 4;

  localparam int OP_UNS_BIT  = 0;
  localparam int OP_REM_BIT  = 1;
  localparam int OP_WORD_BIT = 2;

  localparam logic [2:0] OP_DIV  = 3'b000;
  localparam logic [2:0] OP_DIVU = 3'b001;
  localparam logic [2:0] OP_REM  = 3'b010;
  localparam logic [2:0] OP_REMU = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/divider_request_controller_smc.sv
// Two's-complement <-> sign-magnitude conversion: both directions are a
// conditional negation, the caller decides the sign.
module sign_magnitude_converter #(
  parameter int W = 64
) (
  input  logic         i_negate,
  input  logic [W-1:0] i_value,
  output logic [W-1:0] o_value
);

  assign o_value = i_negate ? -i_value : i_value;

endmodule

// File: rtl/divider_request_controller.sv
// Front end for multicycle_divider: sign-magnitude issue, local bypass of
// divide-by-zero / overflow. Optional word ops via DIVIDER_WORD_OPS_EN.
module divider_request_controller
  import divider_request_controller_pkg::*;
#(
  parameter int OPERAND_WIDTH_IN_BITS = DEFAULT_W,
  parameter int TAG_WIDTH             = DEFAULT_TAG_W
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             flush_in,
  input  logic                             req_valid_in,
  output logic                             req_ready_out,
  input  logic [2:0]                       req_op_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] req_rs1_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] req_rs2_in,
  input  logic [TAG_WIDTH-1:0]             req_tag_in,
  output logic                             resp_valid_out,
  input  logic                             resp_ready_in,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] resp_result_out,
  output logic [TAG_WIDTH-1:0]             resp_tag_out,
  output logic                             div_valid_out,
  input  logic                             div_ready_in,
  output logic                             div_dividend_sign_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] div_dividend_out,
  output logic                             div_divisor_sign_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] div_divisor_out,
  input  logic                             div_valid_in,
  input  logic                             div_quotient_sign_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] div_quotient_in,
  input  logic                             div_remainder_sign_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] div_remainder_in
);

  localparam int W = OPERAND_WIDTH_IN_BITS;

  state_t r_state;
  state_t w_next;

  logic         w_signed;
  logic         w_rem;
  logic         w_word;
  logic [W-1:0] w_rs1;
  logic [W-1:0] w_rs2;
  logic [W-1:0] w_min;
  logic         w_zero;
  logic         w_ovf;
  logic         w_bypass;
  logic [W-1:0] w_bypass_val;
  logic         w_acc;
  logic         w_dvd_sign;
  logic         w_dvs_sign;
  logic [W-1:0] w_dvd_mag;
  logic [W-1:0] w_dvs_mag;
  logic         w_res_sign;
  logic [W-1:0] w_res_mag;
  logic [W-1:0] w_res_val;

  logic                 r_rem;
  logic                 r_word;
  logic [W-1:0]         r_result;
  logic [TAG_WIDTH-1:0] r_tag;
  logic                 r_dvd_sign;
  logic [W-1:0]         r_dvd_mag;
  logic                 r_dvs_sign;
  logic [W-1:0]         r_dvs_mag;

  assign w_signed = !req_op_in[OP_UNS_BIT];
  assign w_rem    = req_op_in[OP_REM_BIT];

`ifdef DIVIDER_WORD_OPS_EN
  assign w_word = req_op_in[OP_WORD_BIT];

  // Word ops see only the low 32 bits, extended per signedness.
  always_comb begin
    w_rs1 = req_rs1_in;
    w_rs2 = req_rs2_in;
    if (w_word) begin
      w_rs1 = {{(W-32){w_signed & req_rs1_in[31]}}, req_rs1_in[31:0]};
      w_rs2 = {{(W-32){w_signed & req_rs2_in[31]}}, req_rs2_in[31:0]};
    end
  end
`else
  logic w_unused_word;
  assign w_unused_word = req_op_in[OP_WORD_BIT];
  assign w_word        = 1'b0;
  assign w_rs1         = req_rs1_in;
  assign w_rs2         = req_rs2_in;
`endif

  assign w_min = w_word ? {{(W-31){1'b1}}, {31{1'b0}}}
                        : {1'b1, {(W-1){1'b0}}};
  assign w_zero   = (w_rs2 == '0);
  assign w_ovf    = w_signed && (w_rs1 == w_min) && (&w_rs2);
  assign w_bypass = w_zero || w_ovf;
  assign w_bypass_val = w_zero ? (w_rem ? w_rs1 : '1)
                               : (w_rem ? '0 : w_rs1);

  assign w_dvd_sign = w_signed & w_rs1[W-1];
  assign w_dvs_sign = w_signed & w_rs2[W-1];

  assign w_res_sign = r_rem ? div_remainder_sign_in : div_quotient_sign_in;
  assign w_res_mag  = r_rem ? div_remainder_in : div_quotient_in;

  sign_magnitude_converter #(.W(W)) u_rs1 (
    .i_negate (w_dvd_sign),
    .i_value  (w_rs1),
    .o_value  (w_dvd_mag)
  );

  sign_magnitude_converter #(.W(W)) u_rs2 (
    .i_negate (w_dvs_sign),
    .i_value  (w_rs2),
    .o_value  (w_dvs_mag)
  );

  sign_magnitude_converter #(.W(W)) u_res (
    .i_negate (w_res_sign),
    .i_value  (w_res_mag),
    .o_value  (w_res_val)
  );

  function automatic logic [W-1:0] fmt_res(
    input logic [W-1:0] v,
    input logic         word
  );
    fmt_res = word ? {{(W-32){v[31]}}, v[31:0]} : v;
  endfunction

  assign w_acc = req_ready_out && req_valid_in;

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset_in) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state and handshake outputs; flush overrides normal progress.
  always_comb begin
    w_next         = r_state;
    req_ready_out  = 1'b0;
    div_valid_out  = 1'b0;
    resp_valid_out = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready_out = !flush_in && !reset_in;
        if (w_acc) w_next = w_bypass ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        div_valid_out = !reset_in;
        if (flush_in)          w_next = div_ready_in ? ST_DRAIN : ST_IDLE;
        else if (div_ready_in) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush_in)          w_next = div_valid_in ? ST_IDLE : ST_DRAIN;
        else if (div_valid_in) w_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_out = !reset_in;
        if (flush_in || resp_ready_in) w_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if (div_valid_in) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture, divider operands and registered result.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_rem      <= 1'b0;
      r_word     <= 1'b0;
      r_result   <= '0;
      r_tag      <= '0;
      r_dvd_sign <= 1'b0;
      r_dvd_mag  <= '0;
      r_dvs_sign <= 1'b0;
      r_dvs_mag  <= '0;
    end else begin
      if (w_acc) begin
        r_tag  <= req_tag_in;
        r_rem  <= w_rem;
        r_word <= w_word;
        if (w_bypass) begin
          r_result <= fmt_res(w_bypass_val, w_word);
        end else begin
          r_dvd_sign <= w_dvd_sign;
          r_dvd_mag  <= w_dvd_mag;
          r_dvs_sign <= w_dvs_sign;
          r_dvs_mag  <= w_dvs_mag;
        end
      end
      if (r_state == ST_WAIT && div_valid_in && !flush_in)
        r_result <= fmt_res(w_res_val, r_word);
    end
  end

  assign resp_result_out       = r_result;
  assign resp_tag_out          = r_tag;
  assign div_dividend_sign_out = r_dvd_sign;
  assign div_dividend_out      = r_dvd_mag;
  assign div_divisor_sign_out  = r_dvs_sign;
  assign div_divisor_out       = r_dvs_mag;

endmodule

// File: tb/tb_divider_request_controller.sv
// Bench for divider_request_controller: vector table with divider model,
// scoreboard of expected responses, hand sequences for flush/reset/stall.
module tb_divider_request_controller;

  import divider_request_controller_pkg::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic [2:0]  req_op_in = '0;
  logic [63:0] req_rs1_in = '0;
  logic [63:0] req_rs2_in = '0;
  logic [3:0]  req_tag_in = '0;
  logic        resp_valid_out;
  logic        resp_ready_in = 1'b1;
  logic [63:0] resp_result_out;
  logic [3:0]  resp_tag_out;
  logic        div_valid_out;
  logic        div_ready_in = 1'b0;
  logic        div_dividend_sign_out;
  logic [63:0] div_dividend_out;
  logic        div_divisor_sign_out;
  logic [63:0] div_divisor_out;
  logic        div_valid_in = 1'b0;
  logic        div_quotient_sign_in = 1'b0;
  logic [63:0] div_quotient_in = '0;
  logic        div_remainder_sign_in = 1'b0;
  logic [63:0] div_remainder_in = '0;

  divider_request_controller dut (
    .clk_in                (clk),
    .reset_in              (reset_in),
    .flush_in              (flush_in),
    .req_valid_in          (req_valid_in),
    .req_ready_out         (req_ready_out),
    .req_op_in             (req_op_in),
    .req_rs1_in            (req_rs1_in),
    .req_rs2_in            (req_rs2_in),
    .req_tag_in            (req_tag_in),
    .resp_valid_out        (resp_valid_out),
    .resp_ready_in         (resp_ready_in),
    .resp_result_out       (resp_result_out),
    .resp_tag_out          (resp_tag_out),
    .div_valid_out         (div_valid_out),
    .div_ready_in          (div_ready_in),
    .div_dividend_sign_out (div_dividend_sign_out),
    .div_dividend_out      (div_dividend_out),
    .div_divisor_sign_out  (div_divisor_sign_out),
    .div_divisor_out       (div_divisor_out),
    .div_valid_in          (div_valid_in),
    .div_quotient_sign_in  (div_quotient_sign_in),
    .div_quotient_in       (div_quotient_in),
    .div_remainder_sign_in (div_remainder_sign_in),
    .div_remainder_in      (div_remainder_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [3:0]  tag;
    bit          issue;
    bit          dvd_s;
    logic [63:0] dvd_m;
    bit          dvs_s;
    logic [63:0] dvs_m;
    logic [63:0] res;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
    input logic [3:0] t, input bit iss,
    input bit ds, input logic [63:0] dm,
    input bit vs, input logic [63:0] vm,
    input logic [63:0] r);
    vec_t v;
    v.op = op; v.rs1 = a; v.rs2 = b; v.tag = t; v.issue = iss;
    v.dvd_s = ds; v.dvd_m = dm; v.dvs_s = vs; v.dvs_m = vm; v.res = r;
    return v;
  endfunction

  task automatic nc();
    @(negedge clk);
    req_valid_in = 1'b0;
    div_valid_in = 1'b0;
    div_ready_in = 1'b0;
    flush_in     = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [3:0] t,
                      output bit acc);
    nc();
    req_valid_in = 1'b1;
    req_op_in = op; req_rs1_in = a; req_rs2_in = b; req_tag_in = t;
    #1;
    acc = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (req_ready_out) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    bit   acc, issued, hs, got;
    int   lat, dvk, rk;
    exp_t e, p;
    send(v.op, v.rs1, v.rs2, v.tag, acc);
    e.res = v.res;
    e.tag = v.tag;
    sb.push_back(e);
    issued = 0; hs = 0; got = 0; lat = 0; dvk = -1; rk = 0;
    for (int k = 1; k <= 40; k++) begin
      nc();
      if (hs) begin
        lat++;
        if (lat == 3) begin
          div_valid_in          = 1'b1;
          div_quotient_in       = v.dvd_m / v.dvs_m;
          div_quotient_sign_in  = v.dvd_s ^ v.dvs_s;
          div_remainder_in      = v.dvd_m % v.dvs_m;
          div_remainder_sign_in = v.dvd_s;
          hs  = 0;
          dvk = k;
        end
      end
      #1;
      if (dvk == k)
        check($sformatf("v%0d_dvd_stable", i), div_dividend_out, v.dvd_m);
      if (div_valid_out && !issued) begin
        issued = 1; hs = 1; lat = 0;
        div_ready_in = 1'b1;
        check($sformatf("v%0d_dvd_sign", i), 64'(div_dividend_sign_out), 64'(v.dvd_s));
        check($sformatf("v%0d_dvd_mag", i), div_dividend_out, v.dvd_m);
        check($sformatf("v%0d_dvs_sign", i), 64'(div_divisor_sign_out), 64'(v.dvs_s));
        check($sformatf("v%0d_dvs_mag", i), div_divisor_out, v.dvs_m);
      end
      if (resp_valid_out) begin
        got = 1; rk = k;
        break;
      end
    end
    check($sformatf("v%0d_issued", i), 64'(issued), 64'(v.issue));
    if (!got) begin
      check($sformatf("v%0d_resp_timeout", i), 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      check($sformatf("v%0d_latency", i), 64'(rk),
            64'(v.issue ? dvk + 1 : 1));
      if (sb.size() == 0) begin
        check($sformatf("v%0d_sb_empty", i), 64'd0, 64'd1);
      end else begin
        p = sb.pop_front();
        check($sformatf("v%0d_result", i), resp_result_out, p.res);
        check($sformatf("v%0d_tag", i), 64'(resp_tag_out), 64'(p.tag));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit seen;

    vecs.push_back(mk(OP_DIV, 64'd7, 64'd2, 4'h3, 1, 0, 64'd7, 0, 64'd2, 64'd3));
    vecs.push_back(mk(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 4'h5, 1,
                      1, 64'd7, 0, 64'd2, ONES));
    vecs.push_back(mk(OP_DIVU, 64'd5, 64'd0, 4'h6, 0, 0, 0, 0, 0, ONES));
    vecs.push_back(mk(OP_REMU, 64'd5, 64'd0, 4'h7, 0, 0, 0, 0, 0, 64'd5));
    vecs.push_back(mk(OP_DIV, MIN, ONES, 4'h8, 0, 0, 0, 0, 0, MIN));
    vecs.push_back(mk(OP_REM, MIN, ONES, 4'h9, 0, 0, 0, 0, 0, 64'd0));
    vecs.push_back(mk(OP_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 4'hA, 1,
                      1, 64'd100, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2));
    vecs.push_back(mk(OP_DIVU, ONES, 64'd3, 4'hB, 1, 0, ONES, 0, 64'd3,
                      64'h5555_5555_5555_5555));
    vecs.push_back(mk(OP_DIV, MIN, 64'd2, 4'hC, 1, 1, MIN, 0, 64'd2,
                      64'hC000_0000_0000_0000));
    vecs.push_back(mk(OP_REM, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 4'hD, 1,
                      0, 64'd7, 1, 64'd3, 64'd1));
    vecs.push_back(mk(OP_DIV, 64'd0, 64'd5, 4'hE, 1, 0, 0, 0, 64'd5, 64'd0));
    vecs.push_back(mk(OP_DIVU, MIN, ONES, 4'hF, 1, 0, MIN, 0, ONES, 64'd0));
    vecs.push_back(mk(OP_REM, 64'd5, 64'd0, 4'h1, 0, 0, 0, 0, 0, 64'd5));
    vecs.push_back(mk(OP_DIV, 64'd5, 64'd0, 4'h2, 0, 0, 0, 0, 0, ONES));
`ifdef DIVIDER_WORD_OPS_EN
    vecs.push_back(mk(3'b100, 64'h0000_0000_FFFF_FFF9, 64'd2, 4'h4, 1,
                      1, 64'd7, 0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD));
    vecs.push_back(mk(3'b101, 64'h1_FFFF_FFFE, 64'd1, 4'h5, 1,
                      0, 64'hFFFF_FFFE, 0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE));
    vecs.push_back(mk(3'b110, 64'h5_0000_0003, 64'h1_0000_0000, 4'h6, 0,
                      0, 0, 0, 0, 64'd3));
`else
    vecs.push_back(mk(3'b110, 64'h1_0000_0005, 64'h10, 4'h4, 1,
                      0, 64'h1_0000_0005, 0, 64'h10, 64'd5));
    vecs.push_back(mk(3'b100, 64'hFFFF_FFF9, 64'd2, 4'h5, 1,
                      0, 64'hFFFF_FFF9, 0, 64'd2, 64'h7FFF_FFFC));
`endif

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready_out), 64'd0);
    check("rst_resp_valid", 64'(resp_valid_out), 64'd0);
    check("rst_div_valid", 64'(div_valid_out), 64'd0);
    check("rst_result", resp_result_out, 64'd0);
    check("rst_dividend", div_dividend_out, 64'd0);
    @(negedge clk);
    reset_in = 1'b0;
    nc();
    #1;
    check("post_rst_ready", 64'(req_ready_out), 64'd1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Flush in IDLE blocks acceptance
    nc();
    flush_in = 1'b1;
    req_valid_in = 1'b1;
    req_op_in = OP_DIV; req_rs1_in = 64'd9; req_rs2_in = 64'd3;
    #1;
    check("flush_idle_ready", 64'(req_ready_out), 64'd0);
    nc();
    #1;
    check("flush_idle_no_issue", 64'(div_valid_out), 64'd0);

    // Flush in WAIT, divider answers 5 cycles later
    send(OP_DIV, 64'd7, 64'd2, 4'h1, acc);
    nc();
    #1;
    check("fw_issue", 64'(div_valid_out), 64'd1);
    div_ready_in = 1'b1;
    nc();
    flush_in = 1'b1;
    #1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      nc();
      #1;
      if (resp_valid_out || req_ready_out) seen = 1;
    end
    check("fw_drain_quiet", 64'(seen), 64'd0);
    nc();
    div_valid_in = 1'b1;
    div_quotient_in = 64'd3;
    #1;
    check("fw_drain_ready", 64'(req_ready_out), 64'd0);
    nc();
    #1;
    check("fw_ready_after", 64'(req_ready_out), 64'd1);
    check("fw_no_resp", 64'(resp_valid_out), 64'd0);

    // Flush in ISSUE without handshake
    send(OP_DIV, 64'd7, 64'd2, 4'h2, acc);
    nc();
    flush_in = 1'b1;
    #1;
    check("fi_issue", 64'(div_valid_out), 64'd1);
    nc();
    #1;
    check("fi_idle", 64'(req_ready_out), 64'd1);
    check("fi_no_issue", 64'(div_valid_out), 64'd0);

    // Flush in ISSUE with handshake -> drain
    send(OP_DIV, 64'd7, 64'd2, 4'h3, acc);
    nc();
    flush_in = 1'b1;
    div_ready_in = 1'b1;
    nc();
    #1;
    check("fh_drain", 64'(req_ready_out), 64'd0);
    nc();
    div_valid_in = 1'b1;
    nc();
    #1;
    check("fh_idle", 64'(req_ready_out), 64'd1);
    check("fh_no_resp", 64'(resp_valid_out), 64'd0);

    // Flush in RESP drops the response
    send(OP_DIVU, 64'd5, 64'd0, 4'h4, acc);
    nc();
    resp_ready_in = 1'b0;
    #1;
    check("fr_valid", 64'(resp_valid_out), 64'd1);
    flush_in = 1'b1;
    nc();
    #1;
    check("fr_dropped", 64'(resp_valid_out), 64'd0);
    check("fr_ready", 64'(req_ready_out), 64'd1);
    resp_ready_in = 1'b1;

    // Response back-pressure: held stable for 3 cycles
    send(OP_DIV, MIN, ONES, 4'h9, acc);
    resp_ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nc();
      #1;
      check($sformatf("bp_valid%0d", c), 64'(resp_valid_out), 64'd1);
      check($sformatf("bp_result%0d", c), resp_result_out, MIN);
      check($sformatf("bp_tag%0d", c), 64'(resp_tag_out), 64'h9);
    end
    nc();
    resp_ready_in = 1'b1;
    #1;
    check("bp_valid_last", 64'(resp_valid_out), 64'd1);
    nc();
    #1;
    check("bp_done", 64'(resp_valid_out), 64'd0);

    // Reset mid-operation, then a stray divider result
    send(OP_DIV, 64'd7, 64'd2, 4'h5, acc);
    nc();
    div_ready_in = 1'b1;
    nc();
    reset_in = 1'b1;
    #1;
    check("mr_ready_low", 64'(req_ready_out), 64'd0);
    nc();
    reset_in = 1'b0;
    div_valid_in = 1'b1;
    #1;
    check("mr_idle", 64'(req_ready_out), 64'd1);
    nc();
    #1;
    check("mr_no_resp", 64'(resp_valid_out), 64'd0);
    check("mr_ready", 64'(req_ready_out), 64'd1);
    check("mr_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_request_controller.md
# divider_request_controller

Initiator-side front end for `multicycle_divider`. It accepts RISC-V style divide/remainder requests with two's-complement operands and converts them to the divider's sign-magnitude form. It issues them over the divider's valid/ready handshake, collects the quotient and remainder, and converts the selected result back to two's complement. Divide-by-zero and signed overflow are resolved locally without occupying the divider; the block sits between the execute-stage issue logic and the divider.

## Interface
- `OPERAND_WIDTH_IN_BITS`, 64, datapath width W
- `TAG_WIDTH`, 4, opaque request tag width
- `clk_in` in 1: single clock
- `reset_in` in 1: synchronous, active-high reset
- `flush_in` in 1: discard any in-flight request
- `req_valid_in` in 1 / `req_ready_out` out 1: request handshake
- `req_op_in` in 3: operation, {W-variant, REM, unsigned}
- `req_rs1_in`, `req_rs2_in` in W: dividend, divisor
- `req_tag_in` in TAG_WIDTH: echoed on response
- `resp_valid_out` out 1 / `resp_ready_in` in 1: response handshake
- `resp_result_out` out W: result; `resp_tag_out` out TAG_WIDTH: echoed tag
- `div_valid_out` out 1 / `div_ready_in` in 1: issue to divider
- `div_dividend_sign_out` out 1, `div_dividend_out` out W: dividend sign and magnitude
- `div_divisor_sign_out` out 1, `div_divisor_out` out W: divisor sign and magnitude
- `div_valid_in` in 1: divider result pulse
- `div_quotient_sign_in` in 1, `div_quotient_in` in W: quotient sign and magnitude
- `div_remainder_sign_in` in 1, `div_remainder_in` in W: remainder sign and magnitude

## Operation
- Op encoding: 000 DIV, 001 DIVU, 010 REM, 011 REMU; 1xx selects the W-variant of the same op.
- FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: `req_ready_out` = IDLE && !`flush_in`. On accept, operands are captured and classified:
  - Divisor zero → RESP. DIV/DIVU result all-ones; REM/REMU result rs1.
  - Signed op with dividend = MIN and divisor = −1 → RESP. DIV result MIN; REM result 0.
  - Otherwise → ISSUE.
- Operand conversion:
  - Signed op: sign = msb, magnitude = sign ? −x : x. MIN yields magnitude 2^(W−1).
  - Unsigned op: sign 0, magnitude x.
- ISSUE: `div_valid_out`=1. The handshake completes when `div_ready_in` is high in the same cycle; the FSM then moves to WAIT.
- WAIT: on `div_valid_in`, select quotient or remainder and convert it: value = sign ? −mag : mag, truncated to W. Result is registered and the FSM moves to RESP.
- RESP: `resp_valid_out` is held along with stable result and tag until `resp_ready_in` is high, then IDLE.
- Divider operand outputs stay stable from ISSUE until `div_valid_in`.
- Flush behaviour by state:
  - IDLE: request is not accepted.
  - ISSUE without handshake: → IDLE.
  - ISSUE with handshake in the same cycle: → DRAIN.
  - WAIT without `div_valid_in`: → DRAIN.
  - WAIT with `div_valid_in` in the same cycle: result discarded, → IDLE.
  - RESP: response dropped, → IDLE.
- DRAIN: wait for `div_valid_in`, discard the result, → IDLE. `flush_in` in DRAIN has no extra effect.
- `div_valid_in` outside WAIT/DRAIN is ignored.

## Timing
- Reset: state IDLE; `req_ready_out`, `resp_valid_out` and `div_valid_out` are 0 while `reset_in` is high. All data outputs and signs are 0.
- `req_ready_out`=1 in the first cycle after reset deasserts.
- Reset mid-operation returns to IDLE immediately. A later stray `div_valid_in` is ignored.
- Request accepted at cycle N:
  - Bypass cases: `resp_valid_out` at N+1.
  - Normal cases: `div_valid_out` at N+1; `div_valid_in` at cycle M gives `resp_valid_out` at M+1.
- Minimum back-to-back issue interval: response handshake cycle, then IDLE, then accept.

## Configuration
- `DIVIDER_WORD_OPS_EN` defined:
  - op[2]=1 operates on rs1[31:0] and rs2[31:0], sign-extended (signed ops) or zero-extended (unsigned ops) to W.
  - Zero and overflow checks apply at 32 bits (MIN = 0x8000_0000).
  - Result bits [31:0] are sign-extended to W for all four W ops.
- Undefined: op[2] is ignored and every op is full width.

## Structure
- Shared package holds the op encodings, FSM state enum and the W/TAG defaults.
- One natural sub-module: `sign_magnitude_converter`, a combinational two's-complement ↔ sign-magnitude converter. It is instantiated for rs1, rs2 and the result.

## Test plan
- DIV 7/2 → divider sees (0,7),(0,2); model returns q=(0,3) r=(0,1) → result 3, tag echoed.
- REM −7/2 → divider sees dividend (1,7); model r=(1,1) → result 0xFFFF_FFFF_FFFF_FFFF.
- DIVU 5/0 → result 0xFFFF_FFFF_FFFF_FFFF at N+1, `div_valid_out` never high; REMU 5/0 → 5.
- DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000 with no divider issue; REM → 0.
- Flush in WAIT, divider responds 5 cycles later → no `resp_valid_out`; `req_ready_out` high the cycle after `div_valid_in`.
- With `DIVIDER_WORD_OPS_EN`: DIVW rs1=0x0000_0000_FFFF_FFF9 by 2 → 0xFFFF_FFFF_FFFF_FFFD; `resp_ready_in` held low 3 cycles → result stable.
